// File: rtl/sraml_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sraml_mem_responder
//  Purpose  : Responder end of the sram-like interface. Backs the port with an
//             internal word RAM and answers every accepted request in order,
//             exactly LATENCY edges after acceptance, with up to QUEUE_DEPTH
//             transactions outstanding.
//  Ports    : clk, rst           - clock (rising edge), synchronous active-high reset
//             req, wr, size,     - initiator request; fields are sampled on the
//             addr, wdata          accepting edge only
//             hold               - forces addr_ok low (backpressure injection)
//             addr_ok            - request accepted this cycle when req & addr_ok
//             data_ok, rdata     - registered one-cycle response pulse and read word
//  Revision : 1.0 - initial release
// ============================================================================
module sraml_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        hold,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [3:0]    LAT_C   = 4'(LATENCY);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Per-slot response word (0 for writes) and countdown to the response edge.
  logic [31:0] q_word  [QUEUE_DEPTH];
  logic [3:0]  q_timer [QUEUE_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [ADDR_WIDTH-1:0] widx;
  logic [3:0]            byte_en;
  logic                  accept;
  logic                  pop;
  logic                  unused_addr;

  assign widx        = addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  // Depends only on registered count and the reset/hold inputs, so the
  // initiator can form req from addr_ok without a combinational loop.
  assign addr_ok = ~rst & ~hold & (count < DEPTH_C);
  assign accept  = req & addr_ok;

  // With uniform latency the head is always the oldest entry and therefore
  // the first to mature; a timer of 1 means this edge is its response edge.
  assign pop = (count != '0) && (q_timer[head] == 4'd1);

  always_comb begin
    byte_en = 4'b1111;
    case (size)
      2'd0:    byte_en = 4'b0001 << addr[1:0];
      2'd1:    byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // RAM contents survive reset; writes commit on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      data_ok <= 1'b0;
      rdata   <= 32'h0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_timer[i] <= 4'd0;
    end else begin
      assert (!(accept && (count == DEPTH_C)));

      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_timer[i] != 4'd0) q_timer[i] <= q_timer[i] - 4'd1;
      end

      // Read samples the RAM before this edge's (impossible same-edge) write;
      // every earlier-accepted write is already committed.
      if (accept) begin
        q_word[tail]  <= wr ? 32'h0 : mem[widx];
        q_timer[tail] <= LAT_C;
        tail          <= tail + 1'b1;
      end

      data_ok <= pop;
      rdata   <= pop ? q_word[head] : 32'h0;
      if (pop) head <= head + 1'b1;

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sraml_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sraml_mem_responder
//  Purpose  : Directed self-checking bench for sraml_mem_responder with a
//             response scoreboard (expected word and due cycle per request).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sraml_mem_responder;

  localparam int AW  = 12;
  localparam int LAT = 4;
  localparam int QD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        hold = 1'b0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  sraml_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .hold(hold), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every data_ok must match the oldest expectation.
  always @(negedge clk) begin
    if (data_ok === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected data_ok", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", rdata, e.data);
        check("data_ok cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      check("idle rdata", rdata, 32'h0);
    end
  end

  function automatic logic [3:0] mask_of(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'b0001 << a[1:0];
    if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
    int          budget;
    int          idx;
    logic [3:0]  m;
    logic [31:0] old;
    exp_t        e;
    budget = 60;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    #1;
    while (addr_ok !== 1'b1 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (addr_ok !== 1'b1) begin
      check("accept timeout", 32'd0, 32'd1);
      acc = -1;
      req = 1'b0;
      return;
    end
    acc = cyc + 1;
    idx = int'((a >> 2) & ((32'd1 << AW) - 1));
    if (w) begin
      m   = mask_of(sz, a);
      old = model.exists(idx) ? model[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (m[b]) old[8*b +: 8] = d[8*b +: 8];
      model[idx] = old;
      e.data = 32'h0;
    end else begin
      e.data = model.exists(idx) ? model[idx] : 32'hx;
    end
    e.due = acc + LAT;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      check("drain timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Reset for n cycles with a write request held, checking outputs stay quiet.
  task automatic reset_with_req(input int n);
    #1;
    rst = 1'b1; sb.delete();
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h300; wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset addr_ok", {31'h0, addr_ok}, 32'd0);
      check("reset data_ok", {31'h0, data_ok}, 32'd0);
      check("reset rdata", rdata, 32'h0);
    end
    rst = 1'b0; req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, a4, rel;
    @(negedge clk);
    reset_with_req(3);
    @(negedge clk);

    // Known word at 0x300, then a reset with a write request held against it.
    issue(1'b1, 2'd2, 32'h300, 32'h1111_1111, a0);
    drain();
    reset_with_req(3);
    @(negedge clk);
    issue(1'b0, 2'd2, 32'h300, 32'h0, a0);
    drain();

    // Word write then back-to-back read of the same word.
    issue(1'b1, 2'd2, 32'h100, 32'hDEAD_BEEF, a0);
    issue(1'b0, 2'd2, 32'h100, 32'h0, a1);
    check("back-to-back accept", 32'(a1), 32'(a0 + 1));
    drain();

    // Byte and half writes.
    issue(1'b1, 2'd2, 32'h200, 32'h0, a0);
    issue(1'b1, 2'd0, 32'h203, 32'hAA00_0000, a0);
    issue(1'b1, 2'd1, 32'h200, 32'h0000_1234, a0);
    issue(1'b0, 2'd2, 32'h200, 32'h0, a0);
    issue(1'b1, 2'd2, 32'h204, 32'h0, a0);
    issue(1'b1, 2'd1, 32'h205, 32'h0000_BEEF, a0);
    issue(1'b1, 2'd0, 32'h206, 32'h0077_0000, a0);
    issue(1'b0, 2'd2, 32'h204, 32'h0, a0);
    issue(1'b1, 2'd3, 32'h208, 32'h1234_5678, a0);
    issue(1'b0, 2'd2, 32'h208, 32'h0, a0);
    drain();

    // Upper address bits alias onto the same word.
    issue(1'b1, 2'd2, 32'h0000_4100, 32'hCAFE_F00D, a0);
    issue(1'b0, 2'd2, 32'h100, 32'h0, a0);
    drain();

    // Backpressure.
    hold = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("hold addr_ok", {31'h0, addr_ok}, 32'd0);
    end
    @(negedge clk);
    hold = 1'b0;
    rel  = cyc;
    issue(1'b0, 2'd2, 32'h200, 32'h0, a0);
    check("hold release accept", 32'(a0), 32'(rel + 1));
    drain();

    // Full queue: four back-to-back reads fill it, fifth waits for the first pop.
    issue(1'b0, 2'd2, 32'h100, 32'h0, a0);
    issue(1'b0, 2'd2, 32'h200, 32'h0, a1);
    issue(1'b0, 2'd2, 32'h204, 32'h0, a2);
    issue(1'b0, 2'd2, 32'h300, 32'h0, a3);
    #1;
    check("full addr_ok", {31'h0, addr_ok}, 32'd0);
    issue(1'b0, 2'd2, 32'h208, 32'h0, a4);
    check("accept after full", 32'(a4), 32'(a0 + LAT + 1));
    drain();

    // Reset with three reads outstanding: no responses may emerge.
    issue(1'b0, 2'd2, 32'h100, 32'h0, a0);
    issue(1'b0, 2'd2, 32'h200, 32'h0, a1);
    issue(1'b0, 2'd2, 32'h300, 32'h0, a2);
    reset_with_req(2);
    repeat (LAT + 4) @(negedge clk);
    issue(1'b0, 2'd2, 32'h200, 32'h0, a0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
